// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl
//   Moore-style control FSM for a multicycle RV32I datapath with a shared ALU
//   and a shared memory. The FSM decodes the instruction register fields and
//   drives the per-cycle mux selects and write enables. It waits on a memory
//   ready handshake, traps on illegal instructions and on memory timeouts,
//   and pulses Retire once per instruction.
//
// Parameters
//   STALL_LIMIT  max consecutive MemReady=0 cycles in one memory state before
//                trapping; 0 disables the timeout
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   op/funct3/funct7b5     instruction fields Instr[6:0], [14:12], [30]
//   Zero                   ALU zero flag (used by beq)
//   MemReady               memory completes the current access this cycle
//   ImmSrc                 immediate format: 00 I, 01 S, 10 B, 11 J
//   ALUSrcA / ALUSrcB      ALU operand selects
//   ResultSrc, AdrSrc      result mux select, memory address select
//   ALUControl             000 add, 001 sub, 010 and, 011 or, 101 slt
//   IRWrite, PCWrite, RegWrite, MemWrite   write enables
//   Retire                 one-cycle pulse in the last cycle of an instruction
//   Fault                  high while trapped
module rv_multicycle_ctrl #(
    parameter int unsigned STALL_LIMIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic [2:0] ALUControl,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Retire,
    output logic       Fault
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Counter only has to reach STALL_LIMIT-1; one bit when the limit is tiny
    // or disabled.
    localparam int unsigned       CW        = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;
    localparam bit                USE_LIMIT = (STALL_LIMIT > 0);
    localparam logic [CW-1:0]     LIM_M1    = USE_LIMIT ? CW'(STALL_LIMIT - 1) : '0;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] stall_cnt;
    logic          mem_state;
    logic          timeout;
    logic          alu_legal;
    logic [2:0]    alu_dec;

    assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    // Last allowed stalled cycle: leave for TRAP instead of waiting again.
    assign timeout   = USE_LIMIT && mem_state && !MemReady && (stall_cnt == LIM_M1);

    // ALU operation from funct3; only four encodings are supported, the rest
    // are caught in DECODE and trap.
    always_comb begin
        alu_dec   = ALU_ADD;
        alu_legal = 1'b1;
        case (funct3)
            3'b000:  alu_dec = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    // Stall counter: counts consecutive not-ready cycles within one memory state
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (state_n != state || MemReady || !mem_state)
            stall_cnt <= '0;
        else if (stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

    // Next state
    always_comb begin
        state_n = state;
        case (state)
            S_FETCH:    state_n = timeout ? S_TRAP : (MemReady ? S_DECODE : S_FETCH);
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_R:         state_n = alu_legal ? S_EXECR : S_TRAP;
                    OP_I:         state_n = alu_legal ? S_EXECI : S_TRAP;
                    OP_BEQ:       state_n = S_BEQ;
                    OP_JAL:       state_n = S_JAL;
                    default:      state_n = S_TRAP;
                endcase
            end
            S_MEMADR:   state_n = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_n = timeout ? S_TRAP : (MemReady ? S_MEMWB : S_MEMREAD);
            S_MEMWB:    state_n = S_FETCH;
            S_MEMWRITE: state_n = timeout ? S_TRAP : (MemReady ? S_FETCH : S_MEMWRITE);
            S_EXECR,
            S_EXECI:    state_n = S_ALUWB;
            S_ALUWB:    state_n = S_FETCH;
            S_BEQ:      state_n = S_FETCH;
            S_JAL:      state_n = S_ALUWB;
            S_TRAP:     state_n = S_TRAP;
            default:    state_n = S_TRAP;
        endcase
    end

    // Outputs
    always_comb begin
        ImmSrc     = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        AdrSrc     = 1'b0;
        ALUControl = ALU_ADD;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        Retire     = 1'b0;
        Fault      = 1'b0;

        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase

        case (state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            S_DECODE: begin
                // Precompute branch/jump target into ALUOut
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                Retire    = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                Retire   = MemReady;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                Retire   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = Zero;
                Retire     = 1'b1;
            end
            S_JAL: begin
                // ALU forms OldPC+4 for rd; PC takes the target held in ALUOut
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_TRAP: begin
                Fault = 1'b1;
            end
            default: begin
                Fault = 1'b1;
            end
        endcase

        // Reset forces FETCH; its MemReady-gated enables must stay quiet too.
        if (reset) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            Retire   = 1'b0;
            Fault    = 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
module tb_rv_multicycle_ctrl;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] LUI = 7'b0110111;

    typedef struct packed {
        logic [1:0] imm, a, b, res;
        logic       adr;
        logic [2:0] alu;
        logic       irw, pcw, regw, memw, ret, flt;
    } ob_t;

    typedef enum int { PF, PD, PMA, PMR, PMWB, PMW, PEX, PWB, PBEQ, PJAL, PTRAP } phase_e;

    logic       clk = 1'b0;
    logic       reset = 1'b1, reset2 = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0, Zero = 1'b0, MemReady = 1'b1, mr2 = 1'b1;

    logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Retire, Fault;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc2, ALUSrcA2, ALUSrcB2, ResultSrc2;
    logic       AdrSrc2, IRWrite2, PCWrite2, RegWrite2, MemWrite2, Retire2, Fault2;
    logic [2:0] ALUControl2;

    int checks = 0, failures = 0;
    ob_t obs;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.STALL_LIMIT(8)) u_dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .ALUControl(ALUControl),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Retire(Retire), .Fault(Fault));

    rv_multicycle_ctrl #(.STALL_LIMIT(2)) u_dut2 (
        .clk(clk), .reset(reset2), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(mr2), .ImmSrc(ImmSrc2), .ALUSrcA(ALUSrcA2),
        .ALUSrcB(ALUSrcB2), .ResultSrc(ResultSrc2), .AdrSrc(AdrSrc2), .ALUControl(ALUControl2),
        .IRWrite(IRWrite2), .PCWrite(PCWrite2), .RegWrite(RegWrite2), .MemWrite(MemWrite2),
        .Retire(Retire2), .Fault(Fault2));

    assign obs = {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
                  IRWrite, PCWrite, RegWrite, MemWrite, Retire, Fault};

    task automatic chk(input string tag, input logic [17:0] o, input logic [17:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Expected controls for one cycle of a phase; m marks the bits that matter.
    function automatic void expect_phase(input phase_e p, input logic mr, input logic z,
                                         output ob_t e, output ob_t m);
        e = '0;
        m = '0;
        m.imm = '1; m.irw = 1; m.pcw = 1; m.regw = 1; m.memw = 1; m.ret = 1; m.flt = 1;
        e.imm = (op == SW) ? 2'd1 : (op == BEQ) ? 2'd2 : (op == JAL) ? 2'd3 : 2'd0;
        case (p)
            PF: begin
                e.adr = 0; e.a = 0; e.b = 2; e.alu = 0; e.res = 2; e.irw = mr; e.pcw = mr;
                m.adr = 1; m.a = '1; m.b = '1; m.alu = '1; m.res = '1;
            end
            PD:  begin e.a = 1; e.b = 1; e.alu = 0; m.a = '1; m.b = '1; m.alu = '1; end
            PMA: begin e.a = 2; e.b = 1; e.alu = 0; m.a = '1; m.b = '1; m.alu = '1; end
            PMR: begin e.adr = 1; e.res = 0; m.adr = 1; m.res = '1; end
            PMWB: begin e.res = 1; e.regw = 1; e.ret = 1; m.res = '1; end
            PMW: begin e.adr = 1; e.res = 0; e.memw = 1; e.ret = mr; m.adr = 1; m.res = '1; end
            PEX: begin
                e.a = 2; e.b = (op == RT) ? 2'd0 : 2'd1;
                case (funct3)
                    3'd0:    e.alu = (op[5] && funct7b5) ? 3'd1 : 3'd0;
                    3'd2:    e.alu = 3'd5;
                    3'd6:    e.alu = 3'd3;
                    default: e.alu = 3'd2;
                endcase
                m.a = '1; m.b = '1; m.alu = '1;
            end
            PWB:  begin e.res = 0; e.regw = 1; e.ret = 1; m.res = '1; end
            PBEQ: begin
                e.a = 2; e.b = 0; e.alu = 1; e.res = 0; e.pcw = z; e.ret = 1;
                m.a = '1; m.b = '1; m.alu = '1; m.res = '1;
            end
            PJAL: begin
                e.a = 1; e.b = 2; e.alu = 0; e.res = 0; e.pcw = 1;
                m.a = '1; m.b = '1; m.alu = '1; m.res = '1;
            end
            default: e.flt = 1;
        endcase
    endfunction

    // One clock of a phase: drive at posedge+1, check at posedge+2.
    task automatic step(input phase_e p, input logic mr, input logic z, input string tag);
        ob_t e, m;
        MemReady = mr;
        Zero = z;
        #1;
        expect_phase(p, mr, z, e, m);
        chk($sformatf("%s:%s", tag, p.name()), obs & m, e & m);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        ob_t e, m;
        #1;
        expect_phase(PF, 1'b0, 1'b0, e, m);
        chk(tag, obs & m, e & m);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        chk_reset(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Instruction-level model: expected phase list follows from the opcode.
    // stl < 0 picks 0..3 stalls at random for each memory phase.
    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input int stl);
        phase_e q[$];
        bit     alu_ok, trap;
        int     n;
        op = o; funct3 = f3; funct7b5 = f7;
        alu_ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
        trap = 0;
        q = '{PF, PD};
        if (o == LW)                            begin q.push_back(PMA); q.push_back(PMR); q.push_back(PMWB); end
        else if (o == SW)                       begin q.push_back(PMA); q.push_back(PMW); end
        else if ((o == RT || o == IT) && alu_ok) begin q.push_back(PEX); q.push_back(PWB); end
        else if (o == BEQ)                      q.push_back(PBEQ);
        else if (o == JAL)                      begin q.push_back(PJAL); q.push_back(PWB); end
        else begin
            trap = 1;
            repeat (3) q.push_back(PTRAP);
        end
        foreach (q[i]) begin
            if (q[i] == PF || q[i] == PMR || q[i] == PMW) begin
                n = (stl < 0) ? int'($urandom_range(0, 3)) : stl;
                repeat (n) step(q[i], 1'b0, z, tag);
                step(q[i], 1'b1, z, tag);
            end else begin
                step(q[i], 1'($urandom_range(0, 1)), z, tag);
            end
        end
        if (trap) do_reset({tag, ":rst"});
    endtask

    initial begin
        logic [6:0] ops [6];
        logic [6:0] o;
        ops = '{LW, SW, RT, IT, BEQ, JAL};

        // Reset state: FETCH selects, enables quiet even with MemReady=1
        MemReady = 1'b1;
        chk_reset("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr("lw",       LW,  3'd2, 1'b0, 1'b0, 0);
        run_instr("beq_z1",   BEQ, 3'd0, 1'b0, 1'b1, 0);
        run_instr("beq_z0",   BEQ, 3'd0, 1'b0, 1'b0, 0);
        run_instr("fstall3",  RT,  3'd7, 1'b0, 1'b0, 3);
        run_instr("sub",      RT,  3'd0, 1'b1, 1'b0, 0);
        run_instr("addi_i30", IT,  3'd0, 1'b1, 1'b0, 0);
        run_instr("jal",      JAL, 3'd0, 1'b0, 1'b0, 0);
        run_instr("sw",       SW,  3'd2, 1'b0, 1'b0, 2);
        run_instr("lui",      LUI, 3'd0, 1'b0, 1'b0, 0);
        run_instr("r_f3_1",   RT,  3'd1, 1'b0, 1'b0, 0);

        // Reset while MEMWRITE is waiting: MemWrite must drop before any edge
        op = SW; funct3 = 3'd2; funct7b5 = 1'b0;
        step(PF, 1'b1, 1'b0, "swrst");
        step(PD, 1'b1, 1'b0, "swrst");
        step(PMA, 1'b1, 1'b0, "swrst");
        MemReady = 1'b0;
        #1;
        chk("swrst_memwrite_on", 18'(MemWrite), 18'd1);
        reset = 1'b1;
        #1;
        chk("swrst_memwrite_async_off", 18'(MemWrite), 18'd0);
        chk_reset("swrst_reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Randomized instruction stream, including illegal funct3 encodings
        for (int k = 0; k < 40; k++) begin
            o = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 15) == 0) o = LUI;
            run_instr($sformatf("rnd%0d", k), o, 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        // Second instance, STALL_LIMIT=2: two stalled FETCH cycles then TRAP
        op = RT; funct3 = 3'd0;
        mr2 = 1'b0;
        reset2 = 1'b0;
        #1;
        chk("lim2_c1", {15'd0, IRWrite2, PCWrite2, Fault2}, 18'd0);
        @(posedge clk); #1;
        chk("lim2_c2", {15'd0, IRWrite2, PCWrite2, Fault2}, 18'd0);
        @(posedge clk); #1;
        chk("lim2_trap", {15'd0, IRWrite2, PCWrite2, Fault2}, 18'd1);
        mr2 = 1'b1;
        @(posedge clk); #1;
        chk("lim2_trap_held", {13'd0, IRWrite2, PCWrite2, RegWrite2, MemWrite2, Fault2}, 18'd1);
        reset2 = 1'b1;
        #1;
        chk("lim2_in_reset", {15'd0, IRWrite2, PCWrite2, Fault2}, 18'd0);
        @(posedge clk); #1;
        reset2 = 1'b0;
        #1;
        chk("lim2_back_fetch", {15'd0, IRWrite2, PCWrite2, Fault2}, 18'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard bound on run time
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
